// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: issues sequential reads to a 1-cycle synchronous
// instruction memory and buffers returned words with their PCs for decode.
module instr_prefetch_queue #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  output logic              halted
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = DEPTH[CNT_W:0];

  typedef enum logic {RUN, HALT} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] rsp_pc;
  logic              inflight;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr, rd_ptr_n;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    occupancy;
  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [ADDR_W-1:0] fifo_pc   [DEPTH];
  logic              issue, enq, deq, halt_seen, bypass;
  logic [DATA_W-1:0] head_data_n;
  logic [ADDR_W-1:0] head_pc_n;

  // Stage p0: request issue, throttled so a returning response always has a slot
  assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
  assign issue     = !rst && (state == RUN) && !redirect && (occupancy < DEPTH_C);
  assign imem_req  = issue;
  assign imem_addr = fetch_pc;

  // Stage p1: response capture and dequeue
  assign enq       = inflight && !redirect && (state == RUN);
  assign deq       = (count != '0) && instr_ready && !redirect;
  assign halt_seen = enq && (imem_data == '0);

  assign instr_valid = (count != '0);
  assign halted      = (state == HALT);

  // Head entry after this edge; bypass covers a write landing on an empty queue
  always_comb begin
    rd_ptr_n    = deq ? rd_ptr + PTR_W'(1) : rd_ptr;
    bypass      = enq && (wr_ptr == rd_ptr_n);
    head_data_n = bypass ? imem_data : fifo_data[rd_ptr_n];
    head_pc_n   = bypass ? rsp_pc    : fifo_pc[rd_ptr_n];
  end

  always_comb begin
    state_n = state;
    if (redirect)
      state_n = RUN;
    else if ((state == RUN) && halt_seen)
      state_n = HALT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= RUN;
    else
      state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc   <= '0;
      rsp_pc     <= '0;
      inflight   <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      instr_data <= '0;
      instr_pc   <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc <= fetch_pc + ADDR_W'(1);
        rsp_pc   <= fetch_pc;
      end
      if (enq)
        wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr <= rd_ptr_n;
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      instr_data <= head_data_n;
      instr_pc   <= head_pc_n;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_data[wr_ptr] <= imem_data;
      fifo_pc[wr_ptr]   <= rsp_pc;
    end
  end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Randomized bench for instr_prefetch_queue with a queue-based reference model.
module tb_instr_prefetch_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic [7:0] imem_data;
  logic       redirect;
  logic [7:0] redirect_pc;
  logic       instr_valid;
  logic [7:0] instr_data;
  logic [7:0] instr_pc;
  logic       instr_ready;
  logic       halted;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mem [256];

  typedef struct { logic [7:0] pc; logic [7:0] d; } ent_t;
  ent_t       q[$];
  logic [7:0] m_pc, m_rsp_pc;
  bit         m_infl, m_halt;

  instr_prefetch_queue #(.ADDR_W(8), .DATA_W(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_data(imem_data), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_data(instr_data), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .halted(halted)
  );

  always #5 clk = ~clk;

  // Synchronous memory: data for a request appears the next cycle, junk otherwise
  always @(posedge clk)
    imem_data <= imem_req ? mem[imem_addr] : 8'($urandom);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc = 8'h00; m_rsp_pc = 8'h00; m_infl = 0; m_halt = 0;
  endtask

  task automatic fill_mem(input int zero_odds);
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom_range(1, 255));
      if (zero_odds != 0 && $urandom_range(0, zero_odds - 1) == 0) mem[i] = 8'h00;
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_req"},   imem_req, 0);
    chk({tag, "_addr"},  imem_addr, 0);
    chk({tag, "_valid"}, instr_valid, 0);
    chk({tag, "_data"},  instr_data, 0);
    chk({tag, "_pc"},    instr_pc, 0);
    chk({tag, "_halt"},  halted, 0);
  endtask

  // Called aligned to a falling edge; drives one cycle, checks, advances model.
  task automatic cyc(input bit rdy, input bit rd, input logic [7:0] rpc);
    bit   exp_req, do_deq;
    ent_t e;
    instr_ready = rdy; redirect = rd; redirect_pc = rpc;
    #1;
    exp_req = !m_halt && !rd && (q.size() + int'(m_infl) < 4);
    chk("imem_req", imem_req, exp_req);
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    chk("instr_valid", instr_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("instr_data", instr_data, q[0].d);
      chk("instr_pc", instr_pc, q[0].pc);
    end
    chk("halted", halted, m_halt);
    if (rd) begin
      q.delete();
      m_infl = 0; m_pc = rpc; m_halt = 0;
    end else begin
      do_deq = (q.size() != 0) && rdy;
      if (do_deq) void'(q.pop_front());
      if (m_infl && !m_halt) begin
        e.pc = m_rsp_pc; e.d = mem[m_rsp_pc];
        q.push_back(e);
        if (e.d == 8'h00) m_halt = 1;
      end
      m_infl = exp_req;
      if (exp_req) begin
        m_rsp_pc = m_pc;
        m_pc = m_pc + 8'd1;
      end
    end
    @(negedge clk);
  endtask

  // Asynchronous reset asserted mid-cycle, released on a falling edge.
  task automatic async_reset(input string tag);
    #3 rst = 1'b1;
    #1 chk_zero_outputs(tag);
    @(negedge clk);
    @(negedge clk);
    chk_zero_outputs({tag, "_hold"});
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = 8'h00; instr_ready = 1'b0;
    fill_mem(0);
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
    model_reset();
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    rst = 1'b0;

    // Back-to-back stream from address 0
    repeat (8) cyc(1, 0, 8'h00);

    // Consumer stalled: queue fills, then drains without loss
    @(negedge clk);
    async_reset("rst_a");
    repeat (10) cyc(0, 0, 8'h00);
    repeat (10) cyc(1, 0, 8'h00);

    // Redirect with entries queued and a read in flight
    async_reset("rst_b");
    repeat (4) cyc(0, 0, 8'h00);
    cyc(0, 1, 8'h40);
    repeat (8) cyc(1, 0, 8'h00);

    // Halt on 0x00 at pc 5, stalled consumer while halted, then redirect to 0
    async_reset("rst_c");
    mem[5] = 8'h00;
    repeat (12) cyc(1, 0, 8'h00);
    repeat (4) cyc(0, 0, 8'h00);
    cyc(1, 1, 8'h00);
    repeat (10) cyc(1, 0, 8'h00);

    // PC wrap-around
    cyc(1, 1, 8'hFE);
    repeat (8) cyc(1, 0, 8'h00);

    // Full queue then asynchronous reset
    repeat (8) cyc(0, 0, 8'h00);
    async_reset("rst_full");
    cyc(1, 0, 8'h00);

    // Random traffic with occasional halts, redirects and one reset
    async_reset("rst_rand");
    fill_mem(16);
    for (int i = 0; i < 600; i++) begin
      if (i == 300) async_reset("rst_mid");
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
